fnd_controller: RTL and testbench
=================================

# fnd_controller

- Downstream display stage of the 0–9999 counter.
- Takes the 14-bit count value and drives the 4-digit, common-anode 7-segment display by time-multiplexing one digit at a time.
- Snapshots the count once per scan frame so a frame never mixes two values.
- Converts each digit to BCD and encodes it as active-low segments.

## Interface

Parameters:

- CLK_FREQ, 100_000_000 — system clock frequency in Hz.
- SCAN_HZ, 1000 — digit-advance rate in Hz.
  - DIV = CLK_FREQ/SCAN_HZ, which must be at least 2.

Ports:

- clk  in  1  system clock, rising-edge.
- rst  in  1  reset; synchronous, active-high.
- i_count  in  14  value to display; legal range 0–9999.
- i_dp  in  4  per-digit decimal-point request, active-high; bit 0 is the ones digit.
- i_blank  in  1  forces all digits off while high.
- fnd_com  out  4  digit enables, active-low; bit 0 is the rightmost (ones) digit.
- fnd_data  out  8  segments {dp,g,f,e,d,c,b,a}, active-low.

## Operation

- Scan counter `cnt` runs 0..DIV-1 and wraps. `tick` = (cnt == DIV-1).
- Digit select `sel` (2 bits) advances 0→1→2→3→0 on each tick.
- A frame is one full pass of `sel` through digits 0–3.
- Snapshot `snap_cnt` / `snap_dp` loads i_count / i_dp on the tick where `sel` wraps 3→0. It holds for the rest of the frame.
- BCD split of `snap_cnt`:
  - ones = v%10, tens = (v/10)%10, hundreds = (v/100)%10, thousands = v/1000.
  - The BCD logic may be combinational.
- Segment codes, a–g, active-low with dp=1 (off):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - blank=FF, dash=BF.
- DP: when `snap_dp[sel]` is set, fnd_data[7] is driven to 0.
- Over-range (`snap_cnt` > 9999): every digit shows BF, with DP still applied.
- fnd_com = ~(1<<sel) normally. It is 4'b1111 when i_blank is high.
- Reset values:
  - cnt=0, sel=0, snap_cnt=0, snap_dp=0.
  - fnd_com=4'b1110, fnd_data=8'hC0.
- Reset mid-frame: all state returns to the reset values on the next edge; the first frame after reset shows 0000.

## Timing

- Outputs are registered.
- On the edge where tick=1:
  - `sel` takes sel+1.
  - fnd_com and fnd_data load the pattern for the new `sel` on that same edge.
  - If the new `sel` is 0, the pattern is computed from i_count/i_dp sampled on that edge, not from the old snapshot.
- Each digit is held for exactly DIV cycles; a frame lasts 4·DIV cycles.
- First digit change after rst is released: DIV cycles later (cnt counts up from 0).
- i_blank:
  - Sampled every cycle; fnd_com becomes 1111 on the next edge.
  - On release, fnd_com returns to ~(1<<sel) on the next edge.
  - `cnt` and `sel` keep running while blanked.
- i_count changing mid-frame has no effect until the next 3→0 wrap.
- rst and tick asserted together: rst wins.

## Configuration

- Macro: `FND_LZB_EN`.
- Defined — leading-zero blanking:
  - Every digit above the most significant nonzero digit shows FF.
  - Digit 0 is always shown, so value 0 displays "   0".
  - A blanked digit with DP requested shows 7F.
  - Over-range ignores blanking.
- Undefined: all four digits are always shown, including leading zeros.

## Test plan

All scenarios use CLK_FREQ=100, SCAN_HZ=25, so DIV=4.

- **Reset:** hold rst high 2 cycles with i_count=1234.
  - During reset: fnd_com=1110, fnd_data=C0.
  - After release: 0000 shown for the first frame.
  - The frame after that shows 1234: com 1110/99, then 1101/B0, then 1011/A4, then 0111/F9, each held 4 cycles.
- **Anti-tearing:** during a 1234 frame at sel=2, switch i_count to 5678.
  - Digits 2 and 3 still show A4 and F9.
  - The next frame starts with 1110/80.
- **Over-range and DP:** i_count=10000 with i_dp=4'b0010.
  - Digits show BF, 3F, BF, BF (digit 0 first).
- **Blank:** raise i_blank mid-digit.
  - fnd_com=1111 one cycle later.
  - Release after 6 cycles: the enabled digit matches the uninterrupted scan position.
- **Leading-zero blanking:** i_count=42.
  - With `FND_LZB_EN`: A4, 99, FF, FF.
  - Without it: A4, 99, C0, C0.
  - i_count=0 with `FND_LZB_EN`: C0, FF, FF, FF.
- **Reset mid-frame:** assert rst at sel=3 during a 5678 frame.
  - Next edge: fnd_com=1110, fnd_data=C0, and `cnt` restarts at 0.

Source files
------------

// File: rtl/fnd_controller.sv
// fnd_controller: time-multiplexed driver for a 4-digit common-anode
// 7-segment display showing a 0..9999 count.
// Optional build macro: FND_LZB_EN (leading-zero blanking).
module fnd_controller #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int SCAN_HZ  = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] i_count,
    input  logic [3:0]  i_dp,
    input  logic        i_blank,
    output logic [3:0]  fnd_com,
    output logic [7:0]  fnd_data
);
    // Cycles spent on each digit; must be at least 2.
    localparam int DIV = CLK_FREQ / SCAN_HZ;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    // Digit positions scanned by sel (0 = rightmost / ones).
    localparam logic [1:0] DIG_ONES      = 2'd0;
    localparam logic [1:0] DIG_TENS      = 2'd1;
    localparam logic [1:0] DIG_HUNDREDS  = 2'd2;
    localparam logic [1:0] DIG_THOUSANDS = 2'd3;

    localparam logic [13:0] MAX_VALUE = 14'd9999;

    logic [CW-1:0] cnt;
    logic [1:0]    sel;
    logic [13:0]   snap_cnt;
    logic [3:0]    snap_dp;

    logic          tick;
    logic [1:0]    sel_nxt;
    logic [13:0]   snap_cnt_nxt;
    logic [3:0]    snap_dp_nxt;
    logic [3:0]    bcd_ones;
    logic [3:0]    bcd_tens;
    logic [3:0]    bcd_hund;
    logic [3:0]    bcd_thou;
    logic [3:0]    digit;
    logic          lz_blank;
    logic [7:0]    pattern;

    // Active-low {dp,g..a} code for one decimal digit, dp off.
    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    assign tick = (cnt == CNT_LAST);

    // Next digit/snapshot and the segment pattern for the digit about to be
    // shown. Working from the next-state values lets the registered outputs
    // switch on the same edge as sel, and lets a new frame use the value
    // captured on that very edge.
    always_comb begin
        sel_nxt      = tick ? sel + 2'd1 : sel;
        snap_cnt_nxt = snap_cnt;
        snap_dp_nxt  = snap_dp;
        if (tick && sel == DIG_THOUSANDS) begin
            snap_cnt_nxt = i_count;
            snap_dp_nxt  = i_dp;
        end

        bcd_ones = 4'(snap_cnt_nxt % 14'd10);
        bcd_tens = 4'((snap_cnt_nxt / 14'd10) % 14'd10);
        bcd_hund = 4'((snap_cnt_nxt / 14'd100) % 14'd10);
        bcd_thou = 4'(snap_cnt_nxt / 14'd1000);

        digit = bcd_ones;
        case (sel_nxt)
            DIG_ONES:      digit = bcd_ones;
            DIG_TENS:      digit = bcd_tens;
            DIG_HUNDREDS:  digit = bcd_hund;
            DIG_THOUSANDS: digit = bcd_thou;
            default:       digit = bcd_ones;
        endcase

        lz_blank = 1'b0;
`ifdef FND_LZB_EN
        // A digit is a leading zero when the value is below its place weight;
        // the ones digit is never blanked.
        case (sel_nxt)
            DIG_TENS:      lz_blank = (snap_cnt_nxt < 14'd10);
            DIG_HUNDREDS:  lz_blank = (snap_cnt_nxt < 14'd100);
            DIG_THOUSANDS: lz_blank = (snap_cnt_nxt < 14'd1000);
            default:       lz_blank = 1'b0;
        endcase
`endif

        if (snap_cnt_nxt > MAX_VALUE) begin
            pattern = 8'hBF;
        end else if (lz_blank) begin
            pattern = 8'hFF;
        end else begin
            pattern = seg_decode(digit);
        end
        if (snap_dp_nxt[sel_nxt]) begin
            pattern[7] = 1'b0;
        end
    end

    // Scan counter, digit select, per-frame snapshot and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            sel      <= DIG_ONES;
            snap_cnt <= '0;
            snap_dp  <= '0;
            fnd_com  <= 4'b1110;
            fnd_data <= 8'hC0;
        end else begin
            cnt      <= tick ? '0 : cnt + CW'(1);
            sel      <= sel_nxt;
            snap_cnt <= snap_cnt_nxt;
            snap_dp  <= snap_dp_nxt;
            fnd_com  <= i_blank ? 4'b1111 : ~(4'b0001 << sel_nxt);
            fnd_data <= pattern;
        end
    end
endmodule

// File: tb/tb_fnd_controller.sv
// tb_fnd_controller: directed and random stimulus for fnd_controller,
// checked every cycle against a time-indexed reference model plus literal
// expectations for the directed scenarios.
module tb_fnd_controller;
    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic        clk;
    logic        rst;
    logic [13:0] i_count;
    logic [3:0]  i_dp;
    logic        i_blank;
    logic [3:0]  fnd_com;
    logic [7:0]  fnd_data;

    int pass_cnt;
    int fail_cnt;
    int total_cnt;

    // Reference model: edges since last reset, and the frame's captured value.
    int          m_k;
    logic [13:0] m_snap;
    logic [3:0]  m_dp;

    logic [7:0] seg_tbl [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    fnd_controller #(
        .CLK_FREQ(100),
        .SCAN_HZ (25)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_count (i_count),
        .i_dp    (i_dp),
        .i_blank (i_blank),
        .fnd_com (fnd_com),
        .fnd_data(fnd_data)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected segment byte for digit position pos of value v.
    function automatic logic [7:0] ref_pattern(input int v, input logic [3:0] dp, input int pos);
        int p10;
        int dgt;
        logic [7:0] s;
        p10 = 1;
        for (int i = 0; i < pos; i++) p10 = p10 * 10;
        dgt = (v / p10) % 10;
        if (v > 9999) s = 8'hBF;
`ifdef FND_LZB_EN
        else if (pos > 0 && v < p10) s = 8'hFF;
`endif
        else s = seg_tbl[dgt];
        if (dp[pos]) s[7] = 1'b0;
        return s;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock, update the model with the inputs seen on that edge,
    // and compare both outputs.
    task automatic step();
        logic [3:0] ec;
        logic [7:0] ed;
        int pos;
        @(posedge clk);
        if (rst) begin
            m_k    = 0;
            m_snap = '0;
            m_dp   = '0;
            ec     = 4'b1110;
            ed     = 8'hC0;
        end else begin
            m_k++;
            pos = (m_k / DIV) % 4;
            if (m_k % FRAME == 0) begin
                m_snap = i_count;
                m_dp   = i_dp;
            end
            ec = i_blank ? 4'b1111 : ~(4'b0001 << pos);
            ed = ref_pattern(int'(m_snap), m_dp, pos);
        end
        #1;
        check("model_com", {4'h0, fnd_com}, {4'h0, ec});
        check("model_data", fnd_data, ed);
    endtask

    task automatic step_lit(input logic [3:0] ec, input logic [7:0] ed);
        step();
        check("lit_com", {4'h0, fnd_com}, {4'h0, ec});
        check("lit_data", fnd_data, ed);
    endtask

    // One whole frame with literal per-digit codes; inputs change after step sw_at.
    task automatic frame_lit(input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3,
                             input int sw_at, input logic [13:0] nc, input logic [3:0] nd);
        logic [7:0] e [4];
        logic [3:0] ec;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        for (int i = 0; i < FRAME; i++) begin
            ec = ~(4'b0001 << (i / DIV));
            step_lit(ec, e[i / DIV]);
            if (i == sw_at) begin
                i_count = nc;
                i_dp    = nd;
            end
        end
    endtask

    // Directed sequence, then random traffic, then the summary.
    initial begin
        logic [3:0] ec;
        int guard;
        pass_cnt = 0; fail_cnt = 0; total_cnt = 0;
        m_k = 0; m_snap = '0; m_dp = '0;
        rst = 1'b1; i_count = 14'd1234; i_dp = 4'b0000; i_blank = 1'b0;

        // Reset held two cycles
        step_lit(4'b1110, 8'hC0);
        step_lit(4'b1110, 8'hC0);
        rst = 1'b0;

        // First frame after reset shows 0000
        for (int i = 1; i < FRAME; i++) begin
            ec = ~(4'b0001 << (i / DIV));
            step_lit(ec, 8'hC0);
        end

        // 1234 frame, then anti-tearing switch to 5678 at digit 2
        frame_lit(8'h99, 8'hB0, 8'hA4, 8'hF9, 0, 14'd1234, 4'b0000);
        frame_lit(8'h99, 8'hB0, 8'hA4, 8'hF9, 8, 14'd5678, 4'b0000);
        frame_lit(8'h80, 8'hF8, 8'h82, 8'h92, 0, 14'd10000, 4'b0010);

        // Over-range with DP on digit 1
        frame_lit(8'hBF, 8'h3F, 8'hBF, 8'hBF, 0, 14'd42, 4'b0000);

        // Leading zeros
`ifdef FND_LZB_EN
        frame_lit(8'hA4, 8'h99, 8'hFF, 8'hFF, 0, 14'd0, 4'b0000);
        frame_lit(8'hC0, 8'hFF, 8'hFF, 8'hFF, 0, 14'd9, 4'b0100);
`else
        frame_lit(8'hA4, 8'h99, 8'hC0, 8'hC0, 0, 14'd0, 4'b0000);
        frame_lit(8'hC0, 8'hC0, 8'hC0, 8'hC0, 0, 14'd9, 4'b0100);
`endif

        // Blank raised mid-digit, released after 6 cycles
        step();
        step();
        i_blank = 1'b1;
        step();
        check("blank_com", {4'h0, fnd_com}, 8'h0F);
        for (int i = 0; i < 5; i++) step();
        i_blank = 1'b0;
        for (int i = 0; i < 2 * DIV; i++) step();

        // Reset at digit 3 of a 5678 frame
        i_count = 14'd5678; i_dp = 4'b0000;
        guard = 0;
        while (!(m_k % FRAME == 13 && m_snap == 14'd5678) && guard < 100) begin
            step();
            guard++;
        end
        check("wait_bound", 8'(guard < 100), 8'd1);
        rst = 1'b1;
        step_lit(4'b1110, 8'hC0);
        rst = 1'b0;
        for (int i = 1; i < DIV; i++) step_lit(4'b1110, 8'hC0);
        step_lit(4'b1101, 8'hC0);
        for (int i = 0; i < 2 * FRAME; i++) step();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            rst     = ($urandom_range(0, 63) == 0);
            i_blank = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) i_count = 14'($urandom_range(0, 10999));
            i_dp = 4'($urandom_range(0, 15));
            step();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
